// File: rtl/rx_fifo.sv
// rx_fifo: first-word-fall-through receive buffer between RX deserializer and register read path.
// Define RX_FIFO_THRESH_EN to add the i_thresh / o_thresh_hit watermark output.
module rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [CNT_W-1:0]      o_count,
`ifdef RX_FIFO_THRESH_EN
    output logic                  o_drop,
    input  logic [CNT_W-1:0]      i_thresh,
    output logic                  o_thresh_hit
`else
    output logic                  o_drop
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_drop;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_clear;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_clear = i_rst | i_flush;
    // A push while full is dropped even if a pop frees a slot this cycle
    assign w_push  = i_rx_done & ~w_full;
    assign w_pop   = i_rd_en & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push && !w_clear) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= i_rx_done & w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;
    assign o_drop  = r_drop;

`ifdef RX_FIFO_THRESH_EN
    assign o_thresh_hit = (i_thresh != '0) && (r_count >= i_thresh);
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed stimulus for rx_fifo, checked every cycle against a queue model
// plus hand-computed expectations at key points.
module tb_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          rx_done = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rdata;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          drop;
`ifdef RX_FIFO_THRESH_EN
    logic [CW-1:0] thresh = '0;
    logic          thresh_hit;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] q[$];
    bit            m_drop = 1'b0;

    rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_flush   (flush),
        .i_rx_done (rx_done),
        .i_rx_data (rx_data),
        .i_rd_en   (rd_en),
        .o_rdata   (rdata),
        .o_empty   (empty),
        .o_full    (full),
        .o_count   (count),
`ifdef RX_FIFO_THRESH_EN
        .o_drop      (drop),
        .i_thresh    (thresh),
        .o_thresh_hit(thresh_hit)
`else
        .o_drop    (drop)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of accepted bytes
    always @(posedge clk) begin
        bit was_full;
        bit was_empty;
        if (rst || flush) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_drop = rx_done && was_full;
            if (rd_en && !was_empty) void'(q.pop_front());
            if (rx_done && !was_full) q.push_back(rx_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_full", 32'(full), 32'(q.size() == DEPTH));
            chk("m_drop", 32'(drop), 32'(m_drop));
            if (q.size() != 0) chk("m_rdata", 32'(rdata), 32'(q[0]));
`ifdef RX_FIFO_THRESH_EN
            chk("m_thresh", 32'(thresh_hit),
                32'((thresh != 0) && (q.size() >= int'(thresh))));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        rx_done = 1'b1;
        rx_data = d;
        step();
        rx_done = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_drop", 32'(drop), 0);
        rst = 1'b0;

        // 1: basic push/pop
        push(8'hA5);
        push(8'h3C);
        chk("t1_count", 32'(count), 2);
        chk("t1_empty", 32'(empty), 0);
        chk("t1_rdata", 32'(rdata), 32'h A5);
        pop();
        chk("t1_rdata2", 32'(rdata), 32'h3C);
        chk("t1_count2", 32'(count), 1);
        do_flush();

        // 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) push(DW'(i));
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 16);
        push(8'hFF);
        chk("t2_drop", 32'(drop), 1);
        chk("t2_count_ovf", 32'(count), 16);
        step();
        chk("t2_drop_low", 32'(drop), 0);
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", 32'(rdata), 32'(i));
            pop();
        end
        chk("t2_empty", 32'(empty), 1);

        // 3: push+pop while full
        for (int i = 0; i < 16; i++) push(DW'(i));
        rx_done = 1'b1;
        rx_data = 8'h77;
        rd_en = 1'b1;
        step();
        rx_done = 1'b0;
        rd_en = 1'b0;
        chk("t3_drop", 32'(drop), 1);
        chk("t3_count", 32'(count), 15);
        for (int i = 1; i < 16; i++) begin
            chk("t3_drain", 32'(rdata), 32'(i));
            pop();
        end
        chk("t3_empty", 32'(empty), 1);

        // 4: pop on empty, push+pop on empty
        pop();
        chk("t4_count", 32'(count), 0);
        chk("t4_empty", 32'(empty), 1);
        rx_done = 1'b1;
        rx_data = 8'h5A;
        rd_en = 1'b1;
        step();
        rx_done = 1'b0;
        rd_en = 1'b0;
        chk("t4_count2", 32'(count), 1);
        chk("t4_rdata", 32'(rdata), 32'h5A);
        pop();

        // 5: wrap-around streaming, then flush with concurrent push
        for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
        for (int k = 0; k < 40; k++) begin
            chk("t5_order", 32'(rdata), 32'(8'h10 + k));
            rx_done = 1'b1;
            rx_data = DW'(8'h18 + k);
            rd_en = 1'b1;
            step();
        end
        rx_done = 1'b0;
        rd_en = 1'b0;
        chk("t5_count", 32'(count), 8);
        chk("t5_head", 32'(rdata), 32'h38);
        flush = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'hEE;
        step();
        flush = 1'b0;
        rx_done = 1'b0;
        chk("t5_fl_count", 32'(count), 0);
        chk("t5_fl_empty", 32'(empty), 1);
        chk("t5_fl_drop", 32'(drop), 0);
        for (int i = 0; i < 16; i++) push(DW'(i));
        flush = 1'b1;
        rx_done = 1'b1;
        step();
        flush = 1'b0;
        rx_done = 1'b0;
        chk("t5_flfull_drop", 32'(drop), 0);
        chk("t5_flfull_cnt", 32'(count), 0);

`ifdef RX_FIFO_THRESH_EN
        // 6: watermark
        thresh = CW'(4);
        for (int i = 0; i < 3; i++) push(DW'(i));
        chk("t6_hit3", 32'(thresh_hit), 0);
        push(8'h03);
        chk("t6_hit4", 32'(thresh_hit), 1);
        pop();
        chk("t6_hit_pop", 32'(thresh_hit), 0);
        thresh = '0;
        for (int i = 0; i < 13; i++) push(DW'(i));
        chk("t6_full", 32'(full), 1);
        chk("t6_dis", 32'(thresh_hit), 0);
        thresh = CW'(4);
        step();
        chk("t6_hit_full", 32'(thresh_hit), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_hit", 32'(thresh_hit), 0);
        chk("t6_rst_cnt", 32'(count), 0);
`endif

        step();
        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive-data buffer in UART_RX.
- Sits between the RX deserializer (which pulses i_rx_done with a completed byte) and the TL-UL register read path (which pops bytes).
- Its o_full output drives the RX-FIFO-full input of the overrun detector.
- First-word-fall-through: the head entry is always visible on o_rdata while not empty.

Parameters:
- DATA_WIDTH, 8, width of one received character.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH+1), derived width of the occupancy count (5 at default).

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_flush  input  1  synchronous clear from control register; same effect as reset on FIFO state.
- i_rx_done  input  1  one-cycle push strobe from the RX deserializer.
- i_rx_data  input  DATA_WIDTH  character to push; sampled when i_rx_done=1.
- i_rd_en  input  1  pop strobe from the register read path.
- o_rdata  output  DATA_WIDTH  head entry (FWFT); valid only when o_empty=0.
- o_empty  output  1  high when count==0.
- o_full  output  1  high when count==DEPTH.
- o_count  output  CNT_W  current occupancy, 0..DEPTH.
- o_drop  output  1  one-cycle registered pulse: a push was discarded because the FIFO was full.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0, o_drop=0.
  - Outputs: o_empty=1, o_full=0, o_count=0.
  - o_rdata is don't-care. The storage array is not cleared.
  - Reset has priority over every other input in the same cycle.
- i_flush: same clear as reset, except o_drop is forced to 0 that cycle. Flush has priority over push and pop in the same cycle.
- Pointers:
  - log2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0.
  - full/empty are derived from count, not from pointer compare.
- Push accepted = i_rx_done & ~o_full. On acceptance: mem[wr_ptr] <= i_rx_data and wr_ptr increments.
- Pop accepted = i_rd_en & ~o_empty. On acceptance: rd_ptr increments.
- Count update per cycle:
  - +1 on push only, -1 on pop only.
  - Unchanged when both or neither are accepted.
- Status timing:
  - o_full, o_empty and o_count reflect the registered count; they update the cycle after the edge that changed it.
  - o_rdata = mem[rd_ptr] combinationally from the registered rd_ptr.
- Full boundary:
  - A push while o_full=1 is always dropped, even if a pop is accepted in the same cycle. This keeps the FIFO consistent with the overrun detector, which flags full & rx_done.
  - The pop still proceeds, so count goes DEPTH -> DEPTH-1.
  - o_drop=1 in the following cycle.
- Empty boundary:
  - A pop while o_empty=1 is ignored: no pointer or count change, no error.
  - Push+pop with o_empty=1: the push is accepted, the pop is ignored, and count becomes 1.
- Push+pop when 0<count<DEPTH: both are accepted, count is unchanged, both pointers advance.
- o_drop is high for exactly one cycle per dropped push, and low in all other cycles.
- No combinational path from i_rx_done or i_rd_en to o_full, o_empty or o_count.

Optional Feature:
- Macro: RX_FIFO_THRESH_EN.
- With the macro defined:
  - Adds input i_thresh [CNT_W] and output o_thresh_hit [1].
  - o_thresh_hit = (i_thresh != 0) & (count >= i_thresh), computed from the registered count.
  - o_thresh_hit resets to 0 (count=0). i_thresh=0 disables it (constant 0).
  - Used as the RX watermark interrupt source.
- Without the macro: neither port exists and no threshold logic is generated.

Test Plan (DEPTH=16, DATA_WIDTH=8):
1. Reset, then push 0xA5, 0x3C on consecutive cycles -> o_count=2, o_empty=0, o_rdata=0xA5. Pop once -> o_rdata=0x3C, o_count=1.
2. Push 16 bytes 0x00..0x0F -> o_full=1, o_count=16. A 17th push of 0xFF -> o_drop=1 for one cycle, o_count stays 16. Popping all 16 returns 0x00..0x0F in order, then o_empty=1.
3. With the FIFO full, push 0x77 and pop in the same cycle -> 0x77 dropped, o_drop=1, o_count=15; the remaining 15 pops return 0x01..0x0F.
4. With the FIFO empty, i_rd_en=1 alone -> no change. Push 0x5A and pop in the same cycle -> o_count=1, o_rdata=0x5A.
5. Wrap-around: with 8 entries loaded, interleave 40 push+pop pairs with incrementing data -> o_count stays 8 and data order is preserved across pointer wrap. Assert i_flush mid-stream together with i_rx_done -> o_count=0, o_empty=1, o_drop=0.
6. (RX_FIFO_THRESH_EN) With i_thresh=4: push 3 -> o_thresh_hit=0; push a 4th -> o_thresh_hit=1 the cycle after; pop 1 -> 0. With i_thresh=0, pushing to full keeps o_thresh_hit=0. Assert i_rst while full -> o_thresh_hit=0, o_count=0 on the next cycle.
